// File: rtl/read_sram_if.sv
// Bundle of the request, SRAM-side and packet-output signals of read_sram.
// The slave modport is the block's view; the master modport is the view of whatever drives it.
`ifndef BLK_ADDR_WIDTH
`define BLK_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface read_sram_if #(parameter int LEN_WIDTH = 6);
  logic                       i_rd_req;
  logic [`BLK_ADDR_WIDTH-1:0] i_rd_addr;
  logic [LEN_WIDTH-1:0]       i_rd_len;
  logic                       o_rd_ready;
  logic [`BLK_ADDR_WIDTH-1:0] o_sram_addr;
  logic                       o_sram_r_en;
  logic [`DATA_WIDTH-1:0]     i_sram_data;
  logic [`DATA_WIDTH-1:0]     o_data;
  logic                       o_data_vld;
  logic                       o_data_sop;
  logic                       o_data_eop;
  logic                       i_data_rdy;

  modport slave (
    input  i_rd_req, i_rd_addr, i_rd_len, i_sram_data, i_data_rdy,
    output o_rd_ready, o_sram_addr, o_sram_r_en, o_data, o_data_vld, o_data_sop, o_data_eop
  );

  modport master (
    output i_rd_req, i_rd_addr, i_rd_len, i_sram_data, i_data_rdy,
    input  o_rd_ready, o_sram_addr, o_sram_r_en, o_data, o_data_vld, o_data_sop, o_data_eop
  );
endinterface

// File: rtl/read_sram.sv
// Reads a packet of consecutive SRAM words and streams it out through a small FIFO,
// throttling SRAM reads so that every issued read always has a free buffer slot.
`ifndef BLK_ADDR_WIDTH
`define BLK_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module read_sram #(
  parameter int LEN_WIDTH = 6,
  parameter int BUF_DEPTH = 4
) (
  input logic        i_clk,
  input logic        i_rst_n,
  read_sram_if.slave bus
);
  localparam int AW = `BLK_ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_e;
  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } word_t;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic                 first_q;
  logic                 r_en_q, rvld_q;
  logic [AW-1:0]        sram_addr_q;
  logic                 tag_sop_q, tag_eop_q, ret_sop_q, ret_eop_q;
  word_t                mem_q [BUF_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;

  logic          accept, issue, push, pop, rd_ready;
  logic [CW-1:0] occ;
  word_t         head;

  assign head = mem_q[rd_ptr_q];
  assign push = rvld_q;
  assign pop  = (cnt_q != '0) && bus.i_data_rdy;
  // A read is outstanding from issue until its word lands: the r_en stage and the return stage.
  assign occ  = cnt_q + CW'(r_en_q) + CW'(rvld_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (issue && rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
      DRAIN:   if (pop && head.eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ready = 1'b0;
    accept   = 1'b0;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        rd_ready = 1'b1;
        accept   = bus.i_rd_req && (bus.i_rd_len != '0);
      end
      READ:    issue = (occ < CW'(BUF_DEPTH));
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.i_rd_addr;
      rem_q   <= bus.i_rd_len;
      first_q <= 1'b1;
    end else if (issue) begin
      addr_q  <= addr_q + AW'(1);
      rem_q   <= rem_q - LEN_WIDTH'(1);
      first_q <= 1'b0;
    end
  end

  // sop/eop tags travel alongside the read so the returning word is tagged on write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en_q      <= 1'b0;
      rvld_q      <= 1'b0;
      sram_addr_q <= '0;
      tag_sop_q   <= 1'b0;
      tag_eop_q   <= 1'b0;
      ret_sop_q   <= 1'b0;
      ret_eop_q   <= 1'b0;
    end else begin
      r_en_q    <= issue;
      rvld_q    <= r_en_q;
      ret_sop_q <= tag_sop_q;
      ret_eop_q <= tag_eop_q;
      if (issue) begin
        sram_addr_q <= addr_q;
        tag_sop_q   <= first_q;
        tag_eop_q   <= (rem_q == LEN_WIDTH'(1));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {ret_sop_q, ret_eop_q, bus.i_sram_data};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.o_rd_ready  = rd_ready;
  assign bus.o_sram_r_en = r_en_q;
  assign bus.o_sram_addr = sram_addr_q;
  assign bus.o_data_vld  = (cnt_q != '0);
  assign bus.o_data      = head.data;
  assign bus.o_data_sop  = bus.o_data_vld && head.sop;
  assign bus.o_data_eop  = bus.o_data_vld && head.eop;
endmodule

// File: tb/tb_read_sram.sv
// Scoreboard bench for read_sram: a behavioural SRAM returns address-derived words,
// expected words and read addresses are queued at request time and checked on output.
`timescale 1ns/1ps
module tb_read_sram;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  read_sram_if #(.LEN_WIDTH(6)) bus();
  read_sram #(.LEN_WIDTH(6), .BUF_DEPTH(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_vec = 0, n_err = 0;
  int cyc = 0, ren_cnt = 0, ren_first = 0, ren_last = 0, xfer_cnt = 0;
  logic [33:0] sb[$];
  logic [7:0]  aq[$];
  logic [33:0] held, exp_w;
  logic [7:0]  exp_a;
  logic        hold_q = 1'b0, rdy_chk_q = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sram_word(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.i_sram_data <= bus.o_sram_r_en ? sram_word(bus.o_sram_addr) : 32'h0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q    = 1'b0;
      rdy_chk_q = 1'b0;
    end else begin
      if (rdy_chk_q) chk("rdy_after_eop", bus.o_rd_ready, 1'b1);
      rdy_chk_q = 1'b0;
      if (bus.o_sram_r_en) begin
        ren_cnt++;
        if (ren_cnt == 1) ren_first = cyc;
        ren_last = cyc;
        if (aq.size() == 0) chk("ren_extra", bus.o_sram_r_en, 1'b0);
        else begin
          exp_a = aq.pop_front();
          chk("sram_addr", bus.o_sram_addr, exp_a);
        end
      end
      if (hold_q) chk("hold", {bus.o_data_vld, bus.o_data_sop, bus.o_data_eop, bus.o_data}, {1'b1, held});
      hold_q = bus.o_data_vld && !bus.i_data_rdy;
      held   = {bus.o_data_sop, bus.o_data_eop, bus.o_data};
      if (bus.o_data_vld && bus.i_data_rdy) begin
        xfer_cnt++;
        if (sb.size() == 0) chk("extra_word", bus.o_data_vld, 1'b0);
        else begin
          exp_w = sb.pop_front();
          chk("word", {bus.o_data_sop, bus.o_data_eop, bus.o_data}, exp_w);
        end
        rdy_chk_q = bus.o_data_eop;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [5:0] l);
    int k = 0;
    while (!bus.o_rd_ready && k < 200) begin tick(); k++; end
    chk("ready_wait", bus.o_rd_ready, 1'b1);
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = a;
    bus.i_rd_len  = l;
    for (int i = 0; i < int'(l); i++) begin
      logic [7:0] ai;
      ai = a + 8'(i);
      sb.push_back({i == 0, i == int'(l) - 1, sram_word(ai)});
      aq.push_back(ai);
    end
    tick();
    bus.i_rd_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int k = 0;
    while ((sb.size() != 0 || !bus.o_rd_ready) && k < budget) begin
      tick();
      if (rnd) bus.i_data_rdy = 1'($urandom_range(0, 1));
      k++;
    end
    bus.i_data_rdy = 1'b1;
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int k;
    bit seen;
    bus.i_rd_req = 1'b0; bus.i_rd_addr = '0; bus.i_rd_len = '0; bus.i_data_rdy = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vals", {bus.o_rd_ready, bus.o_sram_r_en, bus.o_sram_addr, bus.o_data_vld,
                     bus.o_data_sop, bus.o_data_eop, bus.o_data}, {1'b1, 1'b0, 8'h0, 3'b0, 32'h0});
    tick(); rst_n = 1'b1;
    tick();

    // len=4 at 0x10, back-to-back issue
    ren_cnt = 0;
    send(8'h10, 6'd4);
    wait_idle(100, 1'b0);
    chk("len4_ren_cnt", ren_cnt, 4);
    chk("len4_ren_span", ren_last - ren_first, 3);

    // len=1, latency to first word
    send(8'h05, 6'd1);
    k = 0;
    while (!bus.o_data_vld && k < 10) begin tick(); k++; end
    chk("latency", k, 3);
    wait_idle(100, 1'b0);

    // len=10 with downstream stalled for 20 cycles
    bus.i_data_rdy = 1'b0;
    ren_cnt = 0;
    send(8'h20, 6'd10);
    repeat (20) tick();
    chk("stall_issued", ren_cnt, 4);
    chk("stall_vld", bus.o_data_vld, 1'b1);
    bus.i_data_rdy = 1'b1;
    wait_idle(200, 1'b0);
    chk("stall_ren_cnt", ren_cnt, 10);

    // address wrap
    send(8'hFF, 6'd3);
    wait_idle(100, 1'b0);

    // len=0 request ignored
    ren_cnt = 0;
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 8'h77; bus.i_rd_len = 6'd0;
    tick();
    bus.i_rd_req = 1'b0;
    repeat (5) tick();
    chk("len0_ren", ren_cnt, 0);
    chk("len0_ready", bus.o_rd_ready, 1'b1);

    // request during READ ignored
    ren_cnt = 0;
    send(8'h40, 6'd6);
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 8'h80; bus.i_rd_len = 6'd3;
    repeat (2) tick();
    bus.i_rd_req = 1'b0;
    wait_idle(100, 1'b0);
    repeat (4) tick();
    chk("busy_req_ren", ren_cnt, 6);

    // random packets with random backpressure
    for (int p = 0; p < 4; p++) begin
      send(8'($urandom_range(0, 255)), 6'($urandom_range(1, 12)));
      wait_idle(400, 1'b1);
    end

    // reset in the middle of a len=8 packet
    k = xfer_cnt;
    send(8'h30, 6'd8);
    while (xfer_cnt < k + 2 && xfer_cnt < k + 100) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_vals", {bus.o_rd_ready, bus.o_sram_r_en, bus.o_sram_addr, bus.o_data_vld,
                        bus.o_data_sop, bus.o_data_eop, bus.o_data}, {1'b1, 1'b0, 8'h0, 3'b0, 32'h0});
    sb.delete();
    aq.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin tick(); seen |= bus.o_data_vld; end
    chk("post_rst_quiet", seen, 1'b0);
    send(8'h50, 6'd2);
    wait_idle(100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
